// File: rtl/mips_16_boot_pkg.sv
// Shared definitions for the MIPS16 boot loader: FSM state encoding,
// default geometry of the instruction memory, pad word and release-delay limits.
package mips_16_boot_pkg;

    // Defaults track the core's instruction memory geometry.
    localparam int BOOT_PC_WIDTH        = 8;
    localparam int BOOT_INSTR_WIDTH     = 16;
    localparam logic [15:0] BOOT_NOP_WORD = 16'h0000;

    // Release delay is held in a 4-bit down-counter, so 1..15 cycles.
    localparam int BOOT_RELEASE_DLY_DEF = 4;
    localparam int BOOT_RELEASE_DLY_MAX = 15;
    localparam int BOOT_DLY_W           = 4;

    typedef enum logic [2:0] {
        BOOT_IDLE = 3'd0,
        BOOT_LOAD = 3'd1,
        BOOT_PAD  = 3'd2,
        BOOT_HOLD = 3'd3,
        BOOT_RUN  = 3'd4,
        BOOT_ERR  = 3'd5
    } boot_state_t;

    // Counter preset for a given release delay; out-of-range requests are clamped.
    function automatic logic [BOOT_DLY_W-1:0] boot_dly_preset(input int dly);
        int d;
        d = dly;
        if (d < 1) d = 1;
        if (d > BOOT_RELEASE_DLY_MAX) d = BOOT_RELEASE_DLY_MAX;
        return BOOT_DLY_W'(d - 1);
    endfunction

endpackage

// File: rtl/mips_16_boot_loader_if.sv
// Instruction word stream between the host source (master) and the boot loader (slave).
interface mips_16_boot_loader_if #(
    parameter int INSTR_WIDTH = 16
);
    logic                   s_valid;
    logic                   s_ready;
    logic [INSTR_WIDTH-1:0] s_data;
    logic                   s_last;

    modport master (output s_valid, output s_data, output s_last, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/mips_16_boot_cksum.sv
// Running XOR of accepted program words, compared against the checksum beat.
module mips_16_boot_cksum #(
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   en,
    input  logic [INSTR_WIDTH-1:0] din,
    input  logic [INSTR_WIDTH-1:0] cmp_data,
    output logic                   match
);

    logic [INSTR_WIDTH-1:0] acc;

    // Accumulator restarts on each new load; clear wins over a same-cycle word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

    assign match = (acc == cmp_data);

endmodule

// File: rtl/mips_16_boot_loader.sv
// MIPS16 boot loader: streams a program into instruction memory, pads the
// unloaded tail with NOPs and holds the core in reset until loading is done.
// Optional feature macro: MIPS16_BOOT_CHECKSUM_EN adds a trailing XOR checksum
// beat after s_last and the sticky err_checksum output.
//
// state | meaning
// IDLE  | after reset, core held in reset, waiting for start
// LOAD  | accepting stream words, one imem write per handshake
// PAD   | writing NOP_WORD to every address after the program
// HOLD  | all writes done, core_rst kept high for RELEASE_DLY cycles
// RUN   | core released, load_done high, start reloads
// ERR   | overflow (or checksum mismatch), core held, only start leaves
import mips_16_boot_pkg::*;

module mips_16_boot_loader #(
    parameter int                     PC_WIDTH    = BOOT_PC_WIDTH,
    parameter int                     INSTR_WIDTH = BOOT_INSTR_WIDTH,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = BOOT_NOP_WORD,
    parameter int                     RELEASE_DLY = BOOT_RELEASE_DLY_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    mips_16_boot_loader_if.slave   s,
    output logic                   imem_we,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   core_rst,
    output logic                   load_done,
    output logic [PC_WIDTH:0]      word_count,
    output logic                   err_overflow
`ifdef MIPS16_BOOT_CHECKSUM_EN
    ,
    output logic                   err_checksum
`endif
);

    localparam int                    DEPTH      = 1 << PC_WIDTH;
    localparam logic [PC_WIDTH:0]     LAST_ADDR  = (PC_WIDTH+1)'(DEPTH - 1);
    localparam logic [BOOT_DLY_W-1:0] DLY_PRESET = boot_dly_preset(RELEASE_DLY);

    boot_state_t           state;
    logic [PC_WIDTH:0]     addr;
    logic [BOOT_DLY_W-1:0] dly_cnt;
    logic                  ready_q;
    logic                  hs;
    logic                  restart;

    assign s.s_ready = ready_q;
    assign hs        = s.s_valid & ready_q;
    assign restart   = start && (state inside {BOOT_IDLE, BOOT_RUN, BOOT_ERR});

`ifdef MIPS16_BOOT_CHECKSUM_EN
    logic cksum_phase;
    logic cksum_match;

    mips_16_boot_cksum #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_cksum (
        .clk      (clk),
        .rst      (rst),
        .clear    (restart),
        .en       (hs && !cksum_phase),
        .din      (s.s_data),
        .cmp_data (s.s_data),
        .match    (cksum_match)
    );
`endif

    // Sequencer: every output is registered here; imem_we is a one-cycle strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= BOOT_IDLE;
            addr         <= '0;
            dly_cnt      <= '0;
            ready_q      <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_rst     <= 1'b1;
            load_done    <= 1'b0;
            word_count   <= '0;
            err_overflow <= 1'b0;
`ifdef MIPS16_BOOT_CHECKSUM_EN
            cksum_phase  <= 1'b0;
            err_checksum <= 1'b0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (restart) begin
                // core_rst rises on the same edge that leaves RUN
                state        <= BOOT_LOAD;
                ready_q      <= 1'b1;
                addr         <= '0;
                word_count   <= '0;
                err_overflow <= 1'b0;
                core_rst     <= 1'b1;
                load_done    <= 1'b0;
`ifdef MIPS16_BOOT_CHECKSUM_EN
                cksum_phase  <= 1'b0;
                err_checksum <= 1'b0;
`endif
            end else begin
                case (state)
                    BOOT_LOAD: begin
                        if (hs) begin
`ifdef MIPS16_BOOT_CHECKSUM_EN
                            if (cksum_phase) begin
                                // checksum beat is consumed but never written to imem
                                ready_q     <= 1'b0;
                                cksum_phase <= 1'b0;
                                if (!cksum_match) begin
                                    err_checksum <= 1'b1;
                                    state        <= BOOT_ERR;
                                end else if (addr[PC_WIDTH]) begin
                                    dly_cnt <= DLY_PRESET;
                                    state   <= BOOT_HOLD;
                                end else begin
                                    state <= BOOT_PAD;
                                end
                            end else begin
                                imem_we    <= 1'b1;
                                imem_addr  <= addr[PC_WIDTH-1:0];
                                imem_wdata <= s.s_data;
                                addr       <= addr + 1'b1;
                                word_count <= word_count + 1'b1;
                                if (s.s_last) begin
                                    cksum_phase <= 1'b1;
                                end else if (addr == LAST_ADDR) begin
                                    ready_q      <= 1'b0;
                                    err_overflow <= 1'b1;
                                    state        <= BOOT_ERR;
                                end
                            end
`else
                            imem_we    <= 1'b1;
                            imem_addr  <= addr[PC_WIDTH-1:0];
                            imem_wdata <= s.s_data;
                            addr       <= addr + 1'b1;
                            word_count <= word_count + 1'b1;
                            if (s.s_last) begin
                                ready_q <= 1'b0;
                                // a program filling the whole memory needs no padding
                                if (addr == LAST_ADDR) begin
                                    dly_cnt <= DLY_PRESET;
                                    state   <= BOOT_HOLD;
                                end else begin
                                    state <= BOOT_PAD;
                                end
                            end else if (addr == LAST_ADDR) begin
                                ready_q      <= 1'b0;
                                err_overflow <= 1'b1;
                                state        <= BOOT_ERR;
                            end
`endif
                        end
                    end
                    BOOT_PAD: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= addr[PC_WIDTH-1:0];
                        imem_wdata <= NOP_WORD;
                        addr       <= addr + 1'b1;
                        if (addr == LAST_ADDR) begin
                            dly_cnt <= DLY_PRESET;
                            state   <= BOOT_HOLD;
                        end
                    end
                    BOOT_HOLD: begin
                        if (dly_cnt == '0) begin
                            core_rst  <= 1'b0;
                            load_done <= 1'b1;
                            state     <= BOOT_RUN;
                        end else begin
                            dly_cnt <= dly_cnt - 1'b1;
                        end
                    end
                    BOOT_IDLE, BOOT_RUN, BOOT_ERR: begin
                    end
                    default: begin
                        ready_q  <= 1'b0;
                        core_rst <= 1'b1;
                        state    <= BOOT_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_16_boot_loader.sv
// Directed bench for mips_16_boot_loader (default build, checksum beat disabled).
module tb_mips_16_boot_loader;
    import mips_16_boot_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        core_rst;
    logic        load_done;
    logic [8:0]  word_count;
    logic        err_overflow;

    mips_16_boot_loader_if #(.INSTR_WIDTH(16)) sif ();

    mips_16_boot_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s            (sif),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .load_done    (load_done),
        .word_count   (word_count),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] mem  [256];
    logic [15:0] expm [256];
    int   wr_cnt = 0;
    int   cyc = 0;
    int   last_we_cyc = 0;
    int   fall_cyc = 0;
    logic prev_core_rst = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // imem model and release-timing monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (imem_we === 1'b1) begin
            mem[imem_addr] = imem_wdata;
            wr_cnt++;
            last_we_cyc = cyc;
        end
        if (prev_core_rst === 1'b1 && core_rst === 1'b0) fall_cyc = cyc;
        prev_core_rst = core_rst;
    end

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 16'hDEAD;
            expm[i] = 16'h0000;
        end
        wr_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [15:0] d, input logic last, input bit gap);
        logic acc;
        int   n;
        if (gap && $urandom_range(0, 1) == 1) begin
            sif.s_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = last;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = sif.s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("push_timeout", 32'(acc), 32'd1);
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (load_done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #1;
        check(tag, 32'(load_done), 32'd1);
    endtask

    task automatic check_image(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== expm[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int rdy_seen;
        sif.s_valid = 1'b0;
        sif.s_data  = 16'h0000;
        sif.s_last  = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready",   32'(sif.s_ready),  32'd0);
        check("rst_imem_we",   32'(imem_we),      32'd0);
        check("rst_core_rst",  32'(core_rst),     32'd1);
        check("rst_load_done", 32'(load_done),    32'd0);
        check("rst_state",     32'(dut.state),    32'(BOOT_IDLE));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset aborts a load after three words
        pulse_start();
        check("t1_state_load", 32'(dut.state), 32'(BOOT_LOAD));
        for (int i = 0; i < 3; i++) push(16'h1001 + 16'(i), 1'b0, 1'b0);
        check("t1_wc3", 32'(word_count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("t1_state",      32'(dut.state),   32'(BOOT_IDLE));
        check("t1_s_ready",    32'(sif.s_ready), 32'd0);
        check("t1_imem_addr",  32'(imem_addr),   32'd0);
        check("t1_imem_wdata", 32'(imem_wdata),  32'd0);
        check("t1_core_rst",   32'(core_rst),    32'd1);
        check("t1_wc",         32'(word_count),  32'd0);
        check("t1_err",        32'(err_overflow),32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t1_idle_hold", 32'(dut.state), 32'(BOOT_IDLE));

        // 2: five words, pad tail, release after 4 cycles
        clear_model();
        for (int i = 0; i < 5; i++) expm[i] = 16'h1001 + 16'(i);
        pulse_start();
        for (int i = 0; i < 5; i++) push(16'h1001 + 16'(i), i == 4, 1'b0);
        wait_run("t2_run");
        check("t2_wc",       32'(word_count), 32'd5);
        check("t2_core_rst", 32'(core_rst),   32'd0);
        check("t2_rel_dly",  32'(fall_cyc - last_we_cyc), 32'd4);
        check("t2_wr_cnt",   32'(wr_cnt),     32'd256);
        check("t2_mem4",     32'(mem[4]),     32'h1005);
        check("t2_mem5",     32'(mem[5]),     32'h0000);
        check_image("t2_image");

        // 5: reload from RUN, start ignored in LOAD and PAD
        clear_model();
        expm[0] = 16'hBEEF;
        expm[1] = 16'h1234;
        pulse_start();
        check("t5_core_rst_up", 32'(core_rst),    32'd1);
        check("t5_done_low",    32'(load_done),   32'd0);
        check("t5_s_ready",     32'(sif.s_ready), 32'd1);
        push(16'hBEEF, 1'b0, 1'b0);
        pulse_start();
        check("t5_ign_load_wc", 32'(word_count), 32'd1);
        check("t5_ign_load_st", 32'(dut.state),  32'(BOOT_LOAD));
        push(16'h1234, 1'b1, 1'b0);
        pulse_start();
        check("t5_ign_pad_st", 32'(dut.state), 32'(BOOT_PAD));
        wait_run("t5_run");
        check("t5_wc", 32'(word_count), 32'd2);
        check_image("t5_image");

        // 3: same program with random valid gaps
        clear_model();
        for (int i = 0; i < 5; i++) expm[i] = 16'h1001 + 16'(i);
        pulse_start();
        for (int i = 0; i < 5; i++) push(16'h1001 + 16'(i), i == 4, 1'b1);
        wait_run("t3_run");
        check("t3_wr_cnt", 32'(wr_cnt),     32'd256);
        check("t3_wc",     32'(word_count), 32'd5);
        check_image("t3_image");

        // 4a: full-depth program, no padding
        clear_model();
        for (int i = 0; i < 256; i++) expm[i] = 16'h2000 + 16'(i);
        pulse_start();
        for (int i = 0; i < 256; i++) push(16'h2000 + 16'(i), i == 255, 1'b0);
        check("t4_hold", 32'(dut.state), 32'(BOOT_HOLD));
        wait_run("t4_run");
        check("t4_wr_cnt",  32'(wr_cnt),     32'd256);
        check("t4_wc",      32'(word_count), 32'd256);
        check("t4_rel_dly", 32'(fall_cyc - last_we_cyc), 32'd4);
        check_image("t4_image");

        // 4b: 256 words without last -> overflow
        clear_model();
        pulse_start();
        for (int i = 0; i < 256; i++) push(16'h3000 + 16'(i), 1'b0, 1'b0);
        check("t4_ovf",      32'(err_overflow), 32'd1);
        check("t4_ovf_st",   32'(dut.state),    32'(BOOT_ERR));
        check("t4_ovf_crst", 32'(core_rst),     32'd1);
        check("t4_ovf_wc",   32'(word_count),   32'd256);
        sif.s_valid = 1'b1;
        sif.s_data  = 16'h3100;
        rdy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sif.s_ready === 1'b1) rdy_seen++;
        end
        sif.s_valid = 1'b0;
        #1;
        check("t4_ovf_noready", 32'(rdy_seen),     32'd0);
        check("t4_ovf_sticky",  32'(err_overflow), 32'd1);
        check("t4_ovf_crst2",   32'(core_rst),     32'd1);
        check("t4_ovf_wr",      32'(wr_cnt),       32'd256);
        check("t4_ovf_mem255",  32'(mem[255]),     32'h30FF);
        @(posedge clk);
        #1;
        pulse_start();
        check("t4_ovf_clr",  32'(err_overflow), 32'd0);
        check("t4_ovf_load", 32'(dut.state),    32'(BOOT_LOAD));
        push(16'h0042, 1'b1, 1'b0);
        wait_run("t4_recover");
        check("t4_rec_crst", 32'(core_rst), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
